// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiplier retiring MUL_STEP bits per cycle,
// radix-2 restoring divider. Define MULDIV_ACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] hilo_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    localparam int MUL_CYC = WIDTH / MUL_STEP;
    localparam int CW      = $clog2(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    typedef struct packed {
        logic               is_div;
        logic               neg_a;    // operand sign, already qualified by signed op
        logic               neg_b;
        logic               b_zero;
`ifdef MULDIV_ACC_EN
        logic               acc;
        logic               acc_sub;
        logic [2*WIDTH-1:0] hilo;
`endif
    } req_t;

    state_t           state;
    req_t             req;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;   // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [WIDTH-1:0] p_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] p_lo;   // multiplier shifting out, product lower half / quotient

    // Operand decode at accept
    logic             sgn_op, is_div_op;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign sgn_op    = !op[0];
    assign is_div_op = (op[2:1] == 2'b01);
    assign a_mag     = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (sgn_op && b[WIDTH-1]) ? -b : b;

    assign in_ready  = (state == S_IDLE) && !reset;

    // Multiply step: add opnd * chunk into the upper half, then shift the whole product right
    logic [WIDTH+MUL_STEP-1:0] mul_part, mul_sum;
    assign mul_part = {{MUL_STEP{1'b0}}, opnd} * {{WIDTH{1'b0}}, p_lo[MUL_STEP-1:0]};
    assign mul_sum  = {{MUL_STEP{1'b0}}, p_hi} + mul_part;

    // Restoring divide step
    logic [WIDTH:0] div_sh, div_diff;
    assign div_sh   = {p_hi, p_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};

    // Sign correction / accumulate, evaluated while in FIX
    logic [2*WIDTH-1:0] prod, res_mul;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

    always_comb begin
        prod = {p_hi, p_lo};
        if (req.neg_a ^ req.neg_b)
            prod = -prod;
        res_mul = prod;
`ifdef MULDIV_ACC_EN
        if (req.acc)
            res_mul = req.acc_sub ? (req.hilo - prod) : (req.hilo + prod);
`endif
        quo = p_lo;
        rem = p_hi;
        if (req.neg_a ^ req.neg_b)
            quo = -quo;
        if (req.neg_a)
            rem = -rem;
        // Divide by zero leaves the dividend in rem, so only the quotient needs forcing
        if (req.b_zero)
            quo = '1;
        fix_hi = req.is_div ? rem : res_mul[2*WIDTH-1:WIDTH];
        fix_lo = req.is_div ? quo : res_mul[WIDTH-1:0];
    end

`ifndef MULDIV_ACC_EN
    logic unused_hilo;
    assign unused_hilo = ^hilo_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            opnd      <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            req       <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    req.is_div  <= is_div_op;
                    req.neg_a   <= sgn_op && a[WIDTH-1];
                    req.neg_b   <= sgn_op && b[WIDTH-1];
                    req.b_zero  <= (b == '0);
`ifdef MULDIV_ACC_EN
                    req.acc     <= op[2];
                    req.acc_sub <= op[1];
                    req.hilo    <= hilo_in;
`endif
                    opnd  <= is_div_op ? b_mag : a_mag;
                    p_lo  <= is_div_op ? a_mag : b_mag;
                    p_hi  <= '0;
                    cnt   <= '0;
                    state <= is_div_op ? S_DIV : S_MUL;
                end
                S_MUL: begin
                    p_hi <= mul_sum[WIDTH+MUL_STEP-1:MUL_STEP];
                    p_lo <= {mul_sum[MUL_STEP-1:0], p_lo[WIDTH-1:MUL_STEP]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(MUL_CYC-1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (!div_diff[WIDTH]) begin
                        p_hi <= div_diff[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        p_hi <= div_sh[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32, MUL_STEP=4; expectations are hand-computed.
module tb_muldiv_iter;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, in_ready, out_valid;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] hilo_in;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .hilo_in(hilo_in), .out_valid(out_valid), .out_ready(out_ready),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check latency and result, optionally stall out_ready, then retire it.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [63:0] hl,
                          input logic [31:0] eh, input logic [31:0] el, input int hold);
        int n, lat;
        lat = (o[2:1] == 2'b01) ? 33 : 9;
        chk({tag, "_ready_in"}, in_ready, 1);
        in_valid = 1'b1; op = o; a = xa; b = xb; hilo_in = hl;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_v"}, out_valid, 1);
            chk({tag, "_hold_hi"}, hi, eh);
            chk({tag, "_hold_lo"}, lo, el);
            chk({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_v"}, out_valid, 0);
        chk({tag, "_drain_rdy"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0; hilo_in = '0;
        #1;
        chk("rst_ready", in_ready, 0);
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_ready2", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rel_ready", in_ready, 1);

        run_op("mult_neg", 3'b000, 32'hFFFFFFFE, 32'd3, 64'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        run_op("mult_mix", 3'b000, 32'hFFFFFFFD, 32'd7, 64'd0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("mult_min", 3'b000, 32'h80000000, 32'h80000000, 64'd0, 32'h40000000, 32'h0, 0);
        run_op("divu", 3'b011, 32'd100, 32'd7, 64'd0, 32'd2, 32'd14, 0);
        run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 64'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 64'd0, 32'h0, 32'h80000000, 0);
        run_op("divu_z", 3'b011, 32'd5, 32'd0, 64'd0, 32'd5, 32'hFFFFFFFF, 0);
        run_op("div_z", 3'b010, 32'hFFFFFFFB, 32'd0, 64'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);

        // Flush during a divide: no result, unit idle afterwards, hi/lo untouched
        in_valid = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        tick();
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", in_ready, 1);
        chk("flush_hi", hi, 32'hFFFFFFFB);
        chk("flush_lo", lo, 32'hFFFFFFFF);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        chk("flush_never_valid", seen, 0);
        run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 32'hFFFFFFFE, 32'h1, 0);

        // A request presented together with flush is not accepted
        in_valid = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_req_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        chk("flush_req_dropped", seen, 0);

        run_op("stall", 3'b000, 32'd2, 32'hFFFFFFFD, 64'd0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        run_op("b2b", 3'b001, 32'd6, 32'd7, 64'd0, 32'd0, 32'd42, 0);

`ifdef MULDIV_ACC_EN
        run_op("madd", 3'b100, 32'd2, 32'd3, 64'h10, 32'd0, 32'h16, 0);
        run_op("msub", 3'b110, 32'd1, 32'd1, 64'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("msubu", 3'b111, 32'd2, 32'd3, 64'h1_00000000, 32'h0, 32'hFFFFFFFA, 0);
`else
        run_op("madd", 3'b100, 32'd2, 32'd3, 64'h10, 32'd0, 32'h6, 0);
        run_op("msub", 3'b110, 32'd1, 32'hFFFFFFFF, 64'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("maddu", 3'b101, 32'hFFFFFFFF, 32'd2, 64'h55, 32'd1, 32'hFFFFFFFE, 0);
`endif

        // Reset in the middle of a multiply
        in_valid = 1'b1; op = 3'b001; a = 32'd9; b = 32'd9;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("midrst_ready_hi", in_ready, 0);
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("midrst_rel_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        chk("midrst_no_result", seen, 0);
        run_op("post_rst", 3'b000, 32'd5, 32'd5, 64'd0, 32'd0, 32'd25, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
